// File: rtl/pipe_stage_skid.sv
// Inter-stage pipeline register with valid/ready handshake, a two-entry skid
// buffer for back-pressure and synchronous flush (bubble insert).
//
//  state   | meaning
//  --------+------------------------------------------------------------
//  S_EMPTY | nothing held, out_valid=0, in_ready=1          (occ=0)
//  S_ONE   | main entry held and presented, in_ready=1      (occ=1)
//  S_FULL  | main presented, skid holds the next entry,
//          | in_ready=0                                     (occ=2)
//
// The skid entry is valid exactly when the state is S_FULL, so its valid bit
// is carried by the state register rather than by a separate flop.
module pipe_stage_skid #(
    parameter int CTRL_W = 4,
    parameter int DATA_W = 32,
    parameter int DEST_W = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [DATA_W-1:0] in_alu,
    input  logic [DATA_W-1:0] in_rt,
    input  logic [DEST_W-1:0] in_dest,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [DATA_W-1:0] out_alu,
    output logic [DATA_W-1:0] out_rt,
    output logic [DEST_W-1:0] out_dest,
    output logic [1:0]        occ
);

    typedef enum logic [1:0] {
        S_EMPTY = 2'd0,
        S_ONE   = 2'd1,
        S_FULL  = 2'd2
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;

    logic              r_main_valid;
    logic [CTRL_W-1:0] r_main_ctrl;
    logic [DATA_W-1:0] r_main_alu;
    logic [DATA_W-1:0] r_main_rt;
    logic [DEST_W-1:0] r_main_dest;

    logic [CTRL_W-1:0] r_skid_ctrl;
    logic [DATA_W-1:0] r_skid_alu;
    logic [DATA_W-1:0] r_skid_rt;
    logic [DEST_W-1:0] r_skid_dest;

    logic              w_in_fire;
    logic              w_out_fire;
    logic              w_load_main_in;
    logic              w_load_main_skid;
    logic              w_load_skid_in;
    logic              w_clr_main;

    assign w_in_fire  = in_valid & in_ready;
    assign w_out_fire = r_main_valid & out_ready;

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_EMPTY;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state and datapath load selects; flush overrides every transition.
    always_comb begin
        w_state_nxt      = r_state;
        w_load_main_in   = 1'b0;
        w_load_main_skid = 1'b0;
        w_load_skid_in   = 1'b0;
        w_clr_main       = 1'b0;
        if (flush) begin
            w_state_nxt = S_EMPTY;
        end else begin
            case (r_state)
                S_EMPTY: begin
                    if (w_in_fire) begin
                        w_state_nxt    = S_ONE;
                        w_load_main_in = 1'b1;
                    end
                end
                S_ONE: begin
                    if (w_in_fire && w_out_fire) begin
                        w_load_main_in = 1'b1;
                    end else if (w_in_fire) begin
                        w_state_nxt    = S_FULL;
                        w_load_skid_in = 1'b1;
                    end else if (w_out_fire) begin
                        w_state_nxt = S_EMPTY;
                        w_clr_main  = 1'b1;
                    end
                end
                S_FULL: begin
                    if (w_out_fire) begin
                        w_state_nxt      = S_ONE;
                        w_load_main_skid = 1'b1;
                    end
                end
                default: begin
                    w_state_nxt = S_EMPTY;
                end
            endcase
        end
    end

    // Outputs: pure decode of registered state, so no in->out combinational path.
    always_comb begin
        in_ready  = 1'b1;
        occ       = 2'd0;
        case (r_state)
            S_EMPTY: begin
                in_ready = 1'b1;
                occ      = 2'd0;
            end
            S_ONE: begin
                in_ready = 1'b1;
                occ      = 2'd1;
            end
            S_FULL: begin
                in_ready = 1'b0;
                occ      = 2'd2;
            end
            default: begin
                in_ready = 1'b1;
                occ      = 2'd0;
            end
        endcase
        out_valid = r_main_valid;
        out_ctrl  = r_main_valid ? r_main_ctrl : '0;
        out_alu   = r_main_alu;
        out_rt    = r_main_rt;
        out_dest  = r_main_dest;
    end

    // Main entry: loaded from input or promoted from skid; data kept stale on drain.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_main_valid <= 1'b0;
            r_main_ctrl  <= '0;
            r_main_alu   <= '0;
            r_main_rt    <= '0;
            r_main_dest  <= '0;
        end else if (flush) begin
            r_main_valid <= 1'b0;
            r_main_ctrl  <= '0;
            r_main_alu   <= '0;
            r_main_rt    <= '0;
            r_main_dest  <= '0;
        end else if (w_load_main_in) begin
            r_main_valid <= 1'b1;
            r_main_ctrl  <= in_ctrl;
            r_main_alu   <= in_alu;
            r_main_rt    <= in_rt;
            r_main_dest  <= in_dest;
        end else if (w_load_main_skid) begin
            r_main_valid <= 1'b1;
            r_main_ctrl  <= r_skid_ctrl;
            r_main_alu   <= r_skid_alu;
            r_main_rt    <= r_skid_rt;
            r_main_dest  <= r_skid_dest;
        end else if (w_clr_main) begin
            r_main_valid <= 1'b0;
        end
    end

    // Skid entry: captures the input arriving while main is stalled.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_skid_ctrl <= '0;
            r_skid_alu  <= '0;
            r_skid_rt   <= '0;
            r_skid_dest <= '0;
        end else if (flush) begin
            r_skid_ctrl <= '0;
            r_skid_alu  <= '0;
            r_skid_rt   <= '0;
            r_skid_dest <= '0;
        end else if (w_load_skid_in) begin
            r_skid_ctrl <= in_ctrl;
            r_skid_alu  <= in_alu;
            r_skid_rt   <= in_rt;
            r_skid_dest <= in_dest;
        end
    end

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Directed and randomised checks for the skid-buffered pipeline register.
module tb_pipe_stage_skid;

    logic        clk;
    logic        rst;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  in_ctrl;
    logic [31:0] in_alu;
    logic [31:0] in_rt;
    logic [4:0]  in_dest;
    logic        out_valid;
    logic        out_ready;
    logic [3:0]  out_ctrl;
    logic [31:0] out_alu;
    logic [31:0] out_rt;
    logic [4:0]  out_dest;
    logic [1:0]  occ;

    int n_vec = 0;
    int n_err = 0;

    pipe_stage_skid #(.CTRL_W(4), .DATA_W(32), .DEST_W(5)) dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_ctrl   (in_ctrl),
        .in_alu    (in_alu),
        .in_rt     (in_rt),
        .in_dest   (in_dest),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_ctrl  (out_ctrl),
        .out_alu   (out_alu),
        .out_rt    (out_rt),
        .out_dest  (out_dest),
        .occ       (occ)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance to 1 time unit after the next rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [3:0] c, input logic [31:0] a,
                         input logic [31:0] r, input logic [4:0] d);
        in_valid = v;
        in_ctrl  = c;
        in_alu   = a;
        in_rt    = r;
        in_dest  = d;
    endtask

    // Leaves the stage FULL holding A (main) and B (skid), out_ready=0.
    task automatic fill_ab();
        out_ready = 1'b0;
        drive(1'b1, 4'b1010, 32'h0000_A0A0, 32'h0000_1111, 5'd3);
        step();
        drive(1'b1, 4'b0101, 32'h0000_B0B0, 32'h0000_2222, 5'd7);
        step();
        drive(1'b0, 4'b0000, 32'h0, 32'h0, 5'd0);
    endtask

    task automatic test_reset();
        if (occ !== 2'd0 || out_valid !== 1'b0 || in_ready !== 1'b1) begin
            $display("FAIL reset_init occ=%0d ov=%b ir=%b want 0/0/1", occ, out_valid, in_ready);
            n_err++;
        end
        n_vec++;
        fill_ab();
        if (occ !== 2'd2) begin
            $display("FAIL reset_prefill occ=%0d want 2", occ);
            n_err++;
        end
        n_vec++;
        rst = 1'b1;
        #1;
        if (occ !== 2'd0 || out_valid !== 1'b0 || in_ready !== 1'b1 ||
            out_ctrl !== 4'd0 || out_alu !== 32'd0 || out_rt !== 32'd0 || out_dest !== 5'd0) begin
            $display("FAIL reset_async occ=%0d ov=%b ir=%b ctrl=%h alu=%h rt=%h dest=%0d want all 0, ir=1",
                     occ, out_valid, in_ready, out_ctrl, out_alu, out_rt, out_dest);
            n_err++;
        end
        n_vec++;
        step();
        rst = 1'b0;
        step();
    endtask

    task automatic test_stream();
        logic [31:0] vals [3];
        vals[0] = 32'h10;
        vals[1] = 32'h20;
        vals[2] = 32'h30;
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 4'b0001, vals[i], 32'h100 + vals[i], 5'(i + 1));
            step();
            if (out_valid !== 1'b1 || out_alu !== vals[i] || out_rt !== 32'h100 + vals[i] ||
                out_dest !== 5'(i + 1) || occ !== 2'd1 || in_ready !== 1'b1) begin
                $display("FAIL stream_%0d ov=%b alu=%h rt=%h dest=%0d occ=%0d ir=%b want 1/%h/%h/%0d/1/1",
                         i, out_valid, out_alu, out_rt, out_dest, occ, in_ready,
                         vals[i], 32'h100 + vals[i], i + 1);
                n_err++;
            end
            n_vec++;
        end
        drive(1'b0, 4'b0000, 32'h0, 32'h0, 5'd0);
        step();
        if (occ !== 2'd0 || out_valid !== 1'b0) begin
            $display("FAIL stream_drain occ=%0d ov=%b want 0/0", occ, out_valid);
            n_err++;
        end
        n_vec++;
    endtask

    task automatic test_backpressure();
        out_ready = 1'b0;
        drive(1'b1, 4'b1010, 32'h0000_A0A0, 32'h0000_1111, 5'd3);
        step();
        if (occ !== 2'd1 || out_alu !== 32'h0000_A0A0 || out_ctrl !== 4'b1010) begin
            $display("FAIL bp_one occ=%0d alu=%h ctrl=%b want 1/0000a0a0/1010", occ, out_alu, out_ctrl);
            n_err++;
        end
        n_vec++;
        drive(1'b1, 4'b0101, 32'h0000_B0B0, 32'h0000_2222, 5'd7);
        step();
        drive(1'b0, 4'b0000, 32'h0, 32'h0, 5'd0);
        if (occ !== 2'd2 || in_ready !== 1'b0 || out_alu !== 32'h0000_A0A0 ||
            out_ctrl !== 4'b1010 || out_rt !== 32'h0000_1111 || out_dest !== 5'd3) begin
            $display("FAIL bp_full occ=%0d ir=%b alu=%h ctrl=%b rt=%h dest=%0d want 2/0/a0a0/1010/1111/3",
                     occ, in_ready, out_alu, out_ctrl, out_rt, out_dest);
            n_err++;
        end
        n_vec++;
        out_ready = 1'b1;
        step();
        if (occ !== 2'd1 || out_alu !== 32'h0000_B0B0 || out_ctrl !== 4'b0101 ||
            out_rt !== 32'h0000_2222 || out_dest !== 5'd7) begin
            $display("FAIL bp_release occ=%0d alu=%h ctrl=%b rt=%h dest=%0d want 1/b0b0/0101/2222/7",
                     occ, out_alu, out_ctrl, out_rt, out_dest);
            n_err++;
        end
        n_vec++;
        step();
        if (occ !== 2'd0 || out_valid !== 1'b0) begin
            $display("FAIL bp_drain occ=%0d ov=%b want 0/0", occ, out_valid);
            n_err++;
        end
        n_vec++;
    endtask

    task automatic test_full_offer();
        fill_ab();
        out_ready = 1'b1;
        drive(1'b1, 4'b0011, 32'h0000_C0C0, 32'h0000_3333, 5'd9);
        step();
        if (occ !== 2'd1 || out_alu !== 32'h0000_B0B0 || in_ready !== 1'b1) begin
            $display("FAIL full_offer_refused occ=%0d alu=%h ir=%b want 1/b0b0/1", occ, out_alu, in_ready);
            n_err++;
        end
        n_vec++;
        step();
        drive(1'b0, 4'b0000, 32'h0, 32'h0, 5'd0);
        if (occ !== 2'd1 || out_alu !== 32'h0000_C0C0 || out_ctrl !== 4'b0011 || out_dest !== 5'd9) begin
            $display("FAIL full_offer_accept occ=%0d alu=%h ctrl=%b dest=%0d want 1/c0c0/0011/9",
                     occ, out_alu, out_ctrl, out_dest);
            n_err++;
        end
        n_vec++;
        step();
        if (occ !== 2'd0 || out_valid !== 1'b0) begin
            $display("FAIL full_offer_drain occ=%0d ov=%b want 0/0", occ, out_valid);
            n_err++;
        end
        n_vec++;
    endtask

    task automatic test_flush();
        int seen_d;
        fill_ab();
        flush = 1'b1;
        drive(1'b1, 4'b1111, 32'h0000_D0D0, 32'h0000_4444, 5'd31);
        step();
        flush = 1'b0;
        drive(1'b0, 4'b0000, 32'h0, 32'h0, 5'd0);
        if (occ !== 2'd0 || out_valid !== 1'b0 || out_ctrl !== 4'd0 || out_alu !== 32'd0 ||
            in_ready !== 1'b1) begin
            $display("FAIL flush_full occ=%0d ov=%b ctrl=%b alu=%h ir=%b want 0/0/0000/0/1",
                     occ, out_valid, out_ctrl, out_alu, in_ready);
            n_err++;
        end
        n_vec++;
        out_ready = 1'b1;
        seen_d = 0;
        for (int i = 0; i < 4; i++) begin
            step();
            if (out_valid === 1'b1 || out_alu === 32'h0000_D0D0) seen_d++;
        end
        if (seen_d !== 0) begin
            $display("FAIL flush_no_ghost cycles_with_output=%0d want 0", seen_d);
            n_err++;
        end
        n_vec++;
        // Flush on a cycle where downstream also consumes the head.
        drive(1'b1, 4'b0110, 32'h0000_E0E0, 32'h0, 5'd2);
        step();
        flush = 1'b1;
        drive(1'b1, 4'b0111, 32'h0000_F0F0, 32'h0, 5'd4);
        step();
        flush = 1'b0;
        drive(1'b0, 4'b0000, 32'h0, 32'h0, 5'd0);
        if (occ !== 2'd0 || out_valid !== 1'b0) begin
            $display("FAIL flush_with_fire occ=%0d ov=%b want 0/0", occ, out_valid);
            n_err++;
        end
        n_vec++;
    endtask

    task automatic test_bubble();
        out_ready = 1'b1;
        drive(1'b1, 4'b1111, 32'h0000_5A5A, 32'h0, 5'd1);
        step();
        drive(1'b0, 4'b0000, 32'h0, 32'h0, 5'd0);
        if (out_ctrl !== 4'b1111 || out_valid !== 1'b1) begin
            $display("FAIL bubble_head ctrl=%b ov=%b want 1111/1", out_ctrl, out_valid);
            n_err++;
        end
        n_vec++;
        step();
        if (out_valid !== 1'b0 || out_ctrl !== 4'b0000) begin
            $display("FAIL bubble_ctrl ov=%b ctrl=%b want 0/0000", out_valid, out_ctrl);
            n_err++;
        end
        n_vec++;
    endtask

    task automatic test_random();
        logic [72:0] q [$];
        logic [72:0] head;
        logic [72:0] nxt;
        logic        iv;
        logic        ordy;
        int          pushed;
        int          popped;
        int          bad;
        bad    = 0;
        pushed = 0;
        popped = 0;
        drive(1'b0, 4'b0000, 32'h0, 32'h0, 5'd0);
        out_ready = 1'b0;
        for (int cyc = 0; cyc < 10000; cyc++) begin
            if (occ !== 2'(q.size()) || out_valid !== (q.size() > 0) || in_ready !== (q.size() < 2)) begin
                if (bad < 5)
                    $display("FAIL rand_occ cyc=%0d occ=%0d ov=%b ir=%b want occ=%0d",
                             cyc, occ, out_valid, in_ready, q.size());
                bad++;
            end
            if (q.size() > 0) begin
                head = q[0];
                if ({out_ctrl, out_alu, out_rt, out_dest} !== head) begin
                    if (bad < 5)
                        $display("FAIL rand_data cyc=%0d got=%h want=%h",
                                 cyc, {out_ctrl, out_alu, out_rt, out_dest}, head);
                    bad++;
                end
            end else if (out_ctrl !== 4'd0) begin
                if (bad < 5) $display("FAIL rand_bubble cyc=%0d ctrl=%b want 0000", cyc, out_ctrl);
                bad++;
            end
            iv   = 1'($urandom_range(0, 1));
            ordy = 1'($urandom_range(0, 1));
            nxt  = {4'($urandom), 32'(pushed), $urandom, 5'($urandom)};
            drive(iv, nxt[72:69], nxt[68:37], nxt[36:5], nxt[4:0]);
            out_ready = ordy;
            if (ordy && q.size() > 0) begin
                void'(q.pop_front());
                popped++;
            end
            if (iv && in_ready) begin
                q.push_back(nxt);
                pushed++;
            end
            step();
        end
        drive(1'b0, 4'b0000, 32'h0, 32'h0, 5'd0);
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (out_valid === 1'b1 && q.size() > 0) begin
                if ({out_ctrl, out_alu, out_rt, out_dest} !== q[0]) bad++;
                void'(q.pop_front());
                popped++;
            end
            step();
        end
        if (bad !== 0 || q.size() !== 0 || popped !== pushed || occ !== 2'd0) begin
            $display("FAIL rand_scoreboard errors=%0d left=%0d popped=%0d pushed=%0d occ=%0d want 0/0/equal/0",
                     bad, q.size(), popped, pushed, occ);
            n_err++;
        end
        n_vec++;
    endtask

    initial begin
        rst       = 1'b1;
        flush     = 1'b0;
        out_ready = 1'b0;
        drive(1'b0, 4'b0000, 32'h0, 32'h0, 5'd0);
        step();
        step();
        rst = 1'b0;
        step();
        test_reset();
        test_stream();
        test_backpressure();
        test_full_offer();
        test_flush();
        test_bubble();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
